parity_rx: RTL and testbench

- Serial receiver for 7-bit parity-protected frames: the checking end of the 7-bit parity generator path.
- Frame format: start bit (0), D[0]..D[6] LSB first, parity bit, stop bit (1).
- Oversamples the line, recovers the 7-bit word, and checks parity against the configured sense.
- Presents the word and status on a valid/ready interface and keeps a saturating count of bad frames.

---
 rtl/parity_pkg.sv | 24 ++
 rtl/parity_rx_sync_2ff.sv | 32 +++
 rtl/parity_rx.sv | 180 ++++++++++++++++++
 tb/tb_parity_rx.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared definitions for the 7-bit parity frame path (transmitter, receiver, bench).
//   rx_state_t : receiver FSM states
//   DATA_W     : payload width
//   parity_ok  : 1 when XOR of data and parity bit matches the configured sense
package parity_pkg;

  localparam int unsigned DATA_W = 7;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  // odd = 0: even parity (XOR of data and p is 0); odd = 1: odd parity.
  function automatic logic parity_ok(input logic [DATA_W-1:0] data,
                                     input logic              p,
                                     input logic              odd);
    return ((^data) ^ p) == odd;
  endfunction

endpackage

// File: rtl/parity_rx_sync_2ff.sv
// Two-flop synchronizer for one asynchronous input bit.
//   clk, reset_n : clock, asynchronous active-low reset (flops reset to 1)
//   d            : asynchronous input
//   q            : synchronized output, two clocks of latency
module sync_2ff (
  input  logic clk,
  input  logic reset_n,
  input  logic d,
  output logic q
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/parity_rx.sv
// Oversampling serial receiver for 7-bit parity-protected frames.
// Frame: start(0), D[0]..D[6] LSB first, parity, stop(1).
//   clk, reset_n   : clock, asynchronous active-low reset
//   rx_in          : serial line (idles high), synchronized internally
//   rx_data        : received word of the held frame
//   rx_parity_err  : parity mismatch for the held frame
//   rx_frame_err   : stop bit sampled low for the held frame
//   rx_valid/ready : frame handshake; frame consumed when both high
//   overrun        : sticky, a frame completed while the previous one was unconsumed
//   err_count      : saturating count of frames with parity or framing error
//   clr_err        : synchronous clear of err_count and overrun (wins over updates)
module parity_rx
  import parity_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter bit          ODD_PARITY = 1'b0,
  parameter int unsigned ERR_CNT_W  = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx_in,
  output logic [DATA_W-1:0]    rx_data,
  output logic                 rx_parity_err,
  output logic                 rx_frame_err,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic [ERR_CNT_W-1:0] err_count,
  input  logic                 clr_err
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  logic line;

  sync_2ff u_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .d       (rx_in),
    .q       (line)
  );

  rx_state_t          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [2:0]         bit_idx_q, bit_idx_d;
  logic [DATA_W-1:0]  shift_q, shift_d;
  logic               par_q, par_d;

  logic [DATA_W-1:0]    rx_data_q, rx_data_d;
  logic                 rx_parity_err_q, rx_parity_err_d;
  logic                 rx_frame_err_q, rx_frame_err_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 overrun_q, overrun_d;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;

  logic mid;
  logic complete;
  logic par_bad;
  logic frame_bad;

  // Receive FSM. cnt free-runs modulo OVERSAMPLE from the detected start edge,
  // so every bit is sampled at the same phase.
  always_comb begin
    state_d   = state_q;
    cnt_d     = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_d     = par_q;
    complete  = 1'b0;
    mid       = (cnt_q == CNT_MID);
    par_bad   = !parity_ok(shift_q, par_q, ODD_PARITY);
    frame_bad = !line;

    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!line) state_d = START;
      end
      START: begin
        if (mid) begin
          if (line) begin
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = '0;
          end
        end
      end
      DATA: begin
        if (mid) begin
          shift_d = {line, shift_q[DATA_W-1:1]};
          if (bit_idx_q == 3'(DATA_W - 1)) state_d = PARITY;
          else                             bit_idx_d = bit_idx_q + 3'd1;
        end
      end
      PARITY: begin
        if (mid) begin
          par_d   = line;
          state_d = STOP;
        end
      end
      STOP: begin
        // Back to IDLE at the stop midpoint so a following start bit is caught.
        if (mid) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output holding register, handshake, overrun and error counter.
  always_comb begin
    rx_data_d       = rx_data_q;
    rx_parity_err_d = rx_parity_err_q;
    rx_frame_err_d  = rx_frame_err_q;
    rx_valid_d      = rx_valid_q;
    overrun_d       = overrun_q;
    err_count_d     = err_count_q;

    if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

    if (complete) begin
      if (!rx_valid_q || rx_ready) begin
        rx_data_d       = shift_q;
        rx_parity_err_d = par_bad;
        rx_frame_err_d  = frame_bad;
        rx_valid_d      = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
      if ((par_bad || frame_bad) && (err_count_q != '1))
        err_count_d = err_count_q + ERR_CNT_W'(1);
    end

    if (clr_err) begin
      err_count_d = '0;
      overrun_d   = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      par_q           <= 1'b0;
      rx_data_q       <= '0;
      rx_parity_err_q <= 1'b0;
      rx_frame_err_q  <= 1'b0;
      rx_valid_q      <= 1'b0;
      overrun_q       <= 1'b0;
      err_count_q     <= '0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      par_q           <= par_d;
      rx_data_q       <= rx_data_d;
      rx_parity_err_q <= rx_parity_err_d;
      rx_frame_err_q  <= rx_frame_err_d;
      rx_valid_q      <= rx_valid_d;
      overrun_q       <= overrun_d;
      err_count_q     <= err_count_d;
    end
  end

  assign rx_data       = rx_data_q;
  assign rx_parity_err = rx_parity_err_q;
  assign rx_frame_err  = rx_frame_err_q;
  assign rx_valid      = rx_valid_q;
  assign overrun       = overrun_q;
  assign err_count     = err_count_q;

endmodule

// File: tb/tb_parity_rx.sv
// Bench for parity_rx: an even-parity and an odd-parity receiver share one line.
module tb_parity_rx;

  localparam int unsigned OS = 8;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx_in = 1'b1;
  logic       rx_ready = 1'b1;
  logic       clr_err = 1'b0;
  logic [6:0] rx_data [2];
  logic       perr [2];
  logic       ferr [2];
  logic       valid [2];
  logic       ovr [2];
  logic [7:0] ecnt [2];

  int checks = 0;
  int errors = 0;
  int exp_cnt [2];
  logic [8:0] cap0 [$];
  logic [8:0] cap1 [$];

  parity_rx #(.OVERSAMPLE(OS), .ODD_PARITY(1'b0), .ERR_CNT_W(8)) dut_even (
    .clk(clk), .reset_n(reset_n), .rx_in(rx_in),
    .rx_data(rx_data[0]), .rx_parity_err(perr[0]), .rx_frame_err(ferr[0]),
    .rx_valid(valid[0]), .rx_ready(rx_ready), .overrun(ovr[0]),
    .err_count(ecnt[0]), .clr_err(clr_err));

  parity_rx #(.OVERSAMPLE(OS), .ODD_PARITY(1'b1), .ERR_CNT_W(8)) dut_odd (
    .clk(clk), .reset_n(reset_n), .rx_in(rx_in),
    .rx_data(rx_data[1]), .rx_parity_err(perr[1]), .rx_frame_err(ferr[1]),
    .rx_valid(valid[1]), .rx_ready(rx_ready), .overrun(ovr[1]),
    .err_count(ecnt[1]), .clr_err(clr_err));

  always #5 clk = ~clk;

  // Record every accepted frame (valid && ready) as {ferr, perr, data}.
  always @(negedge clk) begin
    if (reset_n && valid[0] && rx_ready) cap0.push_back({ferr[0], perr[0], rx_data[0]});
    if (reset_n && valid[1] && rx_ready) cap1.push_back({ferr[1], perr[1], rx_data[1]});
  end

  // Returns {1, frame} for the oldest accepted frame, or 0 if none arrived.
  function automatic logic [9:0] pop_cap(input int k);
    logic [8:0] v;
    if (k == 0) begin
      if (cap0.size() == 0) return '0;
      v = cap0.pop_front();
    end else begin
      if (cap1.size() == 0) return '0;
      v = cap1.pop_front();
    end
    return {1'b1, v};
  endfunction

  function automatic int cap_size(input int k);
    return (k == 0) ? cap0.size() : cap1.size();
  endfunction

  // Reference model: parity error when the count of ones in D and P has the wrong sense.
  function automatic logic m_perr(input logic [6:0] d, input logic p, input int odd);
    int ones;
    ones = $countones(d) + int'(p);
    return (ones % 2) != odd;
  endfunction

  function automatic logic even_p(input logic [6:0] d);
    return ($countones(d) % 2) == 1;
  endfunction

  task automatic model_frame(input logic [6:0] d, input logic p, input logic stop);
    for (int k = 0; k < 2; k++)
      if ((m_perr(d, p, k) || !stop) && exp_cnt[k] < 255) exp_cnt[k]++;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [6:0] d, input logic p, input logic stop,
                            input int gap_bits);
    logic [9:0] bits;
    bits = {stop, p, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rx_in = bits[i];
      tick(OS);
    end
    rx_in = 1'b1;
    tick(gap_bits * OS);
    model_frame(d, p, stop);
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    tick(3);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rx_data[k], perr[k], ferr[k], valid[k], ovr[k], ecnt[k]} !== '0) begin
        errors++;
        $display("FAIL reset dut%0d: got data=%h perr=%b ferr=%b valid=%b ovr=%b cnt=%0d, expected all 0",
                 k, rx_data[k], perr[k], ferr[k], valid[k], ovr[k], ecnt[k]);
      end
    end
    reset_n = 1'b1;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    tick(4);
  endtask

  task automatic test_directed();
    logic [6:0] td [3];
    logic       tp [3];
    logic       ts [3];
    logic [9:0] got, exp;
    td[0] = 7'h55; tp[0] = 1'b0; ts[0] = 1'b1;
    td[1] = 7'h01; tp[1] = 1'b0; ts[1] = 1'b1;
    td[2] = 7'h7F; tp[2] = 1'b1; ts[2] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      send_frame(td[i], tp[i], ts[i], 2);
      for (int k = 0; k < 2; k++) begin
        got = pop_cap(k);
        exp = {1'b1, !ts[i], m_perr(td[i], tp[i], k), td[i]};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL directed%0d dut%0d frame: got %h expected %h", i, k, got, exp);
        end
        checks++;
        if (cap_size(k) != 0 || valid[k] !== 1'b0) begin
          errors++;
          $display("FAIL directed%0d dut%0d single pulse: extra=%0d valid=%b expected 0/0",
                   i, k, cap_size(k), valid[k]);
        end
        checks++;
        if (ecnt[k] !== 8'(exp_cnt[k])) begin
          errors++;
          $display("FAIL directed%0d dut%0d err_count: got %0d expected %0d", i, k, ecnt[k], exp_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_false_start();
    rx_in = 1'b0;
    tick(3);
    rx_in = 1'b1;
    tick(3 * OS);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cap_size(k) != 0 || valid[k] !== 1'b0 || ecnt[k] !== 8'(exp_cnt[k])) begin
        errors++;
        $display("FAIL false_start dut%0d: frames=%0d valid=%b cnt=%0d expected 0/0/%0d",
                 k, cap_size(k), valid[k], ecnt[k], exp_cnt[k]);
      end
    end
  endtask

  task automatic test_random();
    logic [6:0] d;
    logic       p, s;
    logic [9:0] got, exp;
    for (int i = 0; i < 24; i++) begin
      d = 7'($urandom);
      p = 1'($urandom);
      s = ($urandom_range(0, 3) != 0);
      send_frame(d, p, s, 1);
      for (int k = 0; k < 2; k++) begin
        got = pop_cap(k);
        exp = {1'b1, !s, m_perr(d, p, k), d};
        checks++;
        if (got !== exp) begin
          errors++;
          $display("FAIL random%0d dut%0d frame: got %h expected %h", i, k, got, exp);
        end
        checks++;
        if (ecnt[k] !== 8'(exp_cnt[k])) begin
          errors++;
          $display("FAIL random%0d dut%0d err_count: got %0d expected %0d", i, k, ecnt[k], exp_cnt[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back_overrun();
    logic [9:0] got;
    rx_ready = 1'b0;
    send_frame(7'h12, even_p(7'h12), 1'b1, 0);
    send_frame(7'h34, even_p(7'h34), 1'b1, 1);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (valid[k] !== 1'b1 || rx_data[k] !== 7'h12 || ovr[k] !== 1'b1) begin
        errors++;
        $display("FAIL overrun_hold dut%0d: valid=%b data=%h ovr=%b expected 1/12/1",
                 k, valid[k], rx_data[k], ovr[k]);
      end
      checks++;
      if (ecnt[k] !== 8'(exp_cnt[k])) begin
        errors++;
        $display("FAIL overrun_cnt dut%0d: got %0d expected %0d", k, ecnt[k], exp_cnt[k]);
      end
    end
    rx_ready = 1'b1;
    tick(1);
    for (int k = 0; k < 2; k++) begin
      got = pop_cap(k);
      checks++;
      if (valid[k] !== 1'b0 || got[6:0] !== 7'h12 || got[9] !== 1'b1 || cap_size(k) != 0) begin
        errors++;
        $display("FAIL overrun_accept dut%0d: valid=%b got=%h left=%0d expected 0/12/0",
                 k, valid[k], got, cap_size(k));
      end
      checks++;
      if (ovr[k] !== 1'b1) begin
        errors++;
        $display("FAIL overrun_sticky dut%0d: got %b expected 1", k, ovr[k]);
      end
    end
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (ovr[k] !== 1'b0 || ecnt[k] !== 8'd0) begin
        errors++;
        $display("FAIL clr_err dut%0d: ovr=%b cnt=%0d expected 0/0", k, ovr[k], ecnt[k]);
      end
    end
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 256; i++) begin
      send_frame(7'($urandom), 1'($urandom), 1'b0, 1);
      if (i == 254 || i == 255) begin
        for (int k = 0; k < 2; k++) begin
          checks++;
          if (ecnt[k] !== 8'(exp_cnt[k])) begin
            errors++;
            $display("FAIL saturate%0d dut%0d: got %0d expected %0d", i, k, ecnt[k], exp_cnt[k]);
          end
        end
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (cap_size(k) != 256) begin
        errors++;
        $display("FAIL saturate_frames dut%0d: got %0d expected 256", k, cap_size(k));
      end
    end
    cap0.delete();
    cap1.delete();
  endtask

  task automatic test_reset_mid_frame();
    logic [9:0] got, exp;
    rx_in = 1'b0;
    tick(OS);
    for (int i = 0; i < 3; i++) begin
      rx_in = 1'($urandom);
      tick(OS);
    end
    #2;
    reset_n = 1'b0;
    rx_in = 1'b1;
    #1;
    exp_cnt[0] = 0;
    exp_cnt[1] = 0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({rx_data[k], perr[k], ferr[k], valid[k], ovr[k], ecnt[k]} !== '0) begin
        errors++;
        $display("FAIL reset_mid dut%0d: got data=%h perr=%b ferr=%b valid=%b ovr=%b cnt=%0d, expected all 0",
                 k, rx_data[k], perr[k], ferr[k], valid[k], ovr[k], ecnt[k]);
      end
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick(2 * OS);
    send_frame(7'h2A, even_p(7'h2A), 1'b1, 2);
    for (int k = 0; k < 2; k++) begin
      got = pop_cap(k);
      exp = {1'b1, 1'b0, m_perr(7'h2A, even_p(7'h2A), k), 7'h2A};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL after_reset dut%0d frame: got %h expected %h", k, got, exp);
      end
      checks++;
      if (ecnt[k] !== 8'(exp_cnt[k])) begin
        errors++;
        $display("FAIL after_reset dut%0d err_count: got %0d expected %0d", k, ecnt[k], exp_cnt[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_false_start();
    test_random();
    test_back_to_back_overrun();
    test_saturation();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
